// File: rtl/led_step_pkg.sv
// Shared types for the LED step scheduler.
// Holds op encoding, FSM states and the step arithmetic helper.
package led_step_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  // Next step value for an op on a ring of n states.
  function automatic int step_next(
    input logic [1:0] op,
    input int         cur,
    input int         n
  );
    int r;
    r = cur;
    case (op)
      OP_INC:  r = (cur == n - 1) ? 0 : cur + 1;
      OP_DEC:  r = (cur == 0) ? n - 1 : cur - 1;
      OP_CLR:  r = 0;
      default: r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_step_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit after i_last.
// Ports: i_pending (request vector), i_last (last served), o_any, o_sel.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [ID_W-1:0]  i_last,
  output logic             o_any,
  output logic [ID_W-1:0]  o_sel
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  assign o_any = |i_pending;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    o_sel   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = ID_W'((int'(i_last) + k) % N_REQ);
      if (!w_found && i_pending[w_idx]) begin
        w_found = 1'b1;
        o_sel   = w_idx;
      end
    end
  end

endmodule

// File: rtl/led_step_scheduler.sv
// Round-robin scheduler sharing one step register / one-hot LED bank.
// Ports: clk, rst, req_pulse/req_op in; step, led, grant_*, pending, overrun out.
module led_step_scheduler
  import led_step_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int N_STATES = 4,
  parameter int COOLDOWN = 15,
  parameter int STATE_W  = $clog2(N_STATES),
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_pulse,
  input  logic [2*N_REQ-1:0]   req_op,
  output logic [STATE_W-1:0]   step,
  output logic [N_STATES-1:0]  led,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic [N_REQ-1:0]     pending,
  output logic [N_REQ-1:0]     overrun
);

  localparam logic [CNT_W-1:0] CD_LAST =
    (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [STATE_W-1:0] r_step;
  logic [STATE_W-1:0] w_step_nxt;
  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    r_gid;
  logic               r_gv;
  logic [N_REQ-1:0]   r_pend;
  logic [N_REQ-1:0]   r_ovr;
  logic [1:0]         r_op [N_REQ];

  logic               w_any;
  logic [ID_W-1:0]    w_sel;
  logic               w_pick;
  logic               w_apply;
  logic [N_REQ-1:0]   w_clr;
  logic [N_REQ-1:0]   w_pend_nxt;
  logic [N_REQ-1:0]   w_ovr_nxt;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_pending (r_pend),
    .i_last    (r_last),
    .o_any     (w_any),
    .o_sel     (w_sel)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pick      = 1'b0;
    w_apply     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_pick      = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        w_apply     = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = (COOLDOWN > 0) ? S_COOL : S_IDLE;
      end
      S_COOL: begin
        if (r_cnt == CD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A pulse on the id being cleared re-arms it without counting as overrun.
  always_comb begin
    w_clr      = w_apply ? (N_REQ'(1) << r_gid) : '0;
    w_pend_nxt = req_pulse | (r_pend & ~w_clr);
    w_ovr_nxt  = r_ovr | (req_pulse & r_pend & ~w_clr);
    w_step_nxt = r_step;
    if (w_apply) begin
      w_step_nxt = STATE_W'(step_next(r_op[r_gid],
                                      int'(r_step),
                                      N_STATES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_step  <= '0;
      r_last  <= ID_W'(N_REQ - 1);
      r_gid   <= '0;
      r_gv    <= 1'b0;
      r_pend  <= '0;
      r_ovr   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_op[i] <= OP_HOLD;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_gv    <= w_pick;
      r_pend  <= w_pend_nxt;
      r_ovr   <= w_ovr_nxt;
      if (w_pick) begin
        r_gid <= w_sel;
      end
      if (w_apply) begin
        r_last <= r_gid;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_pulse[i]) begin
          r_op[i] <= req_op[2*i +: 2];
        end
      end
    end
  end

  assign step        = r_step;
  assign led         = N_STATES'(1) << r_step;
  assign grant_valid = r_gv;
  assign grant_id    = r_gid;
  assign pending     = r_pend;
  assign overrun     = r_ovr;

endmodule
